// File: rtl/vip_video_sink.sv
// ----------------------------------------------------------------------------
// vip_video_sink
//   Avalon-ST Video sink (ready latency 1). Parses the packet-ID on the sop
//   beat, keeps video packets (ID 0) and drops everything else. Each video
//   pixel is tagged with its raster X/Y and a last-pixel flag and buffered in
//   a small FIFO. The FIFO is drained through a valid/ready (latency 0) port.
//   Frame completion and frame length errors are reported as 1-cycle pulses.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   st_data/valid/sop/eop Avalon-ST video input beat
//   st_ready              sink ready; qualifies the beat of the NEXT cycle
//   pix_data/x/y/last     head-of-FIFO pixel, its coordinates, last-pixel flag
//   pix_valid, pix_ready  output handshake
//   frame_done            pulse: complete video packet received
//   err_short, err_long   pulse: video packet too short / too long
//   frame_count           number of frame_done pulses (wrapping)
// ----------------------------------------------------------------------------
module vip_video_sink #(
   parameter int VIDEO_W    = 1280,
   parameter int VIDEO_H    = 720,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] st_data,
   input  logic        st_valid,
   input  logic        st_sop,
   input  logic        st_eop,
   output logic        st_ready,
   output logic [23:0] pix_data,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic        pix_last,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        frame_done,
   output logic        err_short,
   output logic        err_long,
   output logic [15:0] frame_count
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [23:0] PIX_TOTAL = 24'(VIDEO_W * VIDEO_H);
   localparam logic [11:0] X_MAX     = 12'(VIDEO_W - 1);
   localparam logic [11:0] Y_MAX     = 12'(VIDEO_H - 1);

   typedef enum logic [1:0] {IDLE, VIDEO, SKIP} state_t;

   state_t        state_q, state_d;
   logic [11:0]   x_q, x_d, y_q, y_d;
   logic [23:0]   count_q, count_d;
   logic          over_q, over_d;
   logic          ready_dly_q, ready_dly_d;
   logic          st_ready_q, st_ready_d;
   logic          frame_done_q, frame_done_d;
   logic          err_short_q, err_short_d;
   logic          err_long_q, err_long_d;
   logic [15:0]   frame_count_q, frame_count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   used_q, used_d;

   logic          accept, push, pop;
   logic [48:0]   push_entry, head_entry;
   logic [48:0]   mem [FIFO_DEPTH];

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      count_d       = count_q;
      over_d        = over_q;
      frame_done_d  = 1'b0;
      err_short_d   = 1'b0;
      err_long_d    = 1'b0;
      push          = 1'b0;
      push_entry    = {st_data, x_q, y_q, (x_q == X_MAX) && (y_q == Y_MAX)};
      accept        = st_valid & ready_dly_q;

      if (accept) begin
         if (st_sop) begin
            // A new sop inside a video packet means the old one was truncated.
            if (state_q == VIDEO)
               err_short_d = 1'b1;
            if (st_data[3:0] == 4'd0) begin
               state_d = VIDEO;
               x_d     = '0;
               y_d     = '0;
               count_d = '0;
               over_d  = 1'b0;
               // Header beat carrying eop: an empty video packet.
               if (st_eop) begin
                  state_d     = IDLE;
                  err_short_d = 1'b1;
               end
            end else begin
               state_d = st_eop ? IDLE : SKIP;
            end
         end else begin
            case (state_q)
               VIDEO: begin
                  if (count_q < PIX_TOTAL) begin
                     push    = 1'b1;
                     count_d = count_q + 24'd1;
                     if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = (y_q == Y_MAX) ? 12'd0 : y_q + 12'd1;
                     end else begin
                        x_d = x_q + 12'd1;
                     end
                  end else begin
                     over_d = 1'b1;
                  end
                  if (st_eop) begin
                     state_d = IDLE;
                     if (over_d)
                        err_long_d = 1'b1;
                     else if (count_d == PIX_TOTAL)
                        frame_done_d = 1'b1;
                     else
                        err_short_d = 1'b1;
                  end
               end
               SKIP: begin
                  if (st_eop)
                     state_d = IDLE;
               end
               default: ;
            endcase
         end
      end

      frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;

      // FIFO bookkeeping
      pop      = (used_q != '0) & pix_ready;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      used_d   = used_q;
      if (push && !pop)
         used_d = used_q + 1'b1;
      else if (pop && !push)
         used_d = used_q - 1'b1;

      // Registering f(used_d) yields f(used_q) in the following cycle, while
      // still forcing st_ready low during reset. Leaving one free slot covers
      // the beat already in flight under ready latency 1.
      st_ready_d  = (int'(used_d) <= FIFO_DEPTH - 2);
      ready_dly_d = st_ready_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         count_q       <= '0;
         over_q        <= 1'b0;
         ready_dly_q   <= 1'b0;
         st_ready_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         err_short_q   <= 1'b0;
         err_long_q    <= 1'b0;
         frame_count_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         used_q        <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         count_q       <= count_d;
         over_q        <= over_d;
         ready_dly_q   <= ready_dly_d;
         st_ready_q    <= st_ready_d;
         frame_done_q  <= frame_done_d;
         err_short_q   <= err_short_d;
         err_long_q    <= err_long_d;
         frame_count_q <= frame_count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         used_q        <= used_d;
      end
   end

   // Pixel storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= push_entry;
   end

   // Head entry is masked while empty so every pix_* output reads 0 then.
   assign head_entry  = mem[rd_ptr_q];
   assign pix_valid   = (used_q != '0);
   assign {pix_data, pix_x, pix_y, pix_last} = pix_valid ? head_entry : 49'd0;

   assign st_ready    = st_ready_q;
   assign frame_done  = frame_done_q;
   assign err_short   = err_short_q;
   assign err_long    = err_long_q;
   assign frame_count = frame_count_q;

endmodule
